// File: rtl/writeback_stage.sv
// writeback_stage: registered N-source result select feeding a DEPTH-entry elastic
// buffer ahead of the register-file write port. Define WB_FWD_EN for forwarding taps.
`timescale 1ns/1ps
module writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 4,
  parameter int DEPTH      = 2,
  localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [SEL_W-1:0]            wb_sel,
  input  logic                        reg_we,
  input  logic [REG_ADDR_W-1:0]       wr_reg,
  input  logic                        halt_in,
  input  logic                        flush,
  output logic                        rf_valid,
  input  logic                        rf_ready,
  output logic                        rf_we,
  output logic [REG_ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
`ifdef WB_FWD_EN
  output logic [DEPTH-1:0]            fwd_valid,
  output logic [DEPTH*REG_ADDR_W-1:0] fwd_reg,
  output logic [DEPTH*DATA_W-1:0]     fwd_data,
`endif
  output logic                        halted,
  output logic                        sel_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SEL_W:0]     NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] dest;
    logic                  writes;
    logic                  halt;
  } entryT;

  entryT            mem [DEPTH];
  entryT            newEntry;
  entryT            head;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             haltedQ;
  logic             selErrQ;
  logic             selBad;
  logic             push;
  logic             pop;
  logic             retireHalt;

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign selBad = {1'b0, wb_sel} >= NUM_SRC_W;

  always_comb begin
    // NOTE: default every field first so no path leaves it unassigned (no latch).
    newEntry        = '0;
    newEntry.writes = reg_we & ~selBad;
    newEntry.dest   = wr_reg;
    newEntry.halt   = halt_in;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (wb_sel == SEL_W'(k)) newEntry.data = src_data[k*DATA_W +: DATA_W];
    end
  end

  // Handshakes depend only on state, so there is no input-to-output comb path.
  assign head       = mem[rdPtr];
  assign in_ready   = (count != FULL_CNT) && !haltedQ;
  assign rf_valid   = (count != '0) && !haltedQ;
  assign push       = in_valid && in_ready;
  assign pop        = rf_valid && rf_ready;
  assign retireHalt = pop && head.halt;

  assign rf_we    = rf_valid && head.writes;
  assign rf_waddr = rf_valid ? head.dest : '0;
  assign rf_wdata = rf_valid ? head.data : '0;
  assign halted   = haltedQ;
  assign sel_err  = selErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      haltedQ <= 1'b0;
      selErrQ <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      selErrQ <= push && selBad;
      if (retireHalt) haltedQ <= 1'b1;
      // A retiring HALT discards everything queued behind it, like a flush.
      if (flush || retireHalt) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (push) wrPtr <= nextPtr(wrPtr);
        if (pop)  rdPtr <= nextPtr(rdPtr);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage is not reset; count qualifies every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newEntry;
  end

`ifdef WB_FWD_EN
  // Slot i is the i-th youngest occupied entry (slot 0 = most recently pushed).
  always_comb begin
    int idx;
    idx       = 0;
    fwd_valid = '0;
    fwd_reg   = '0;
    fwd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = (int'(wrPtr) + 2 * DEPTH - 1 - i) % DEPTH;
      if ((CNT_W'(i) < count) && mem[PTR_W'(idx)].writes) begin
        fwd_valid[i]                          = 1'b1;
        fwd_reg[i*REG_ADDR_W +: REG_ADDR_W]   = mem[PTR_W'(idx)].dest;
        fwd_data[i*DATA_W +: DATA_W]          = mem[PTR_W'(idx)].data;
      end
    end
  end
`endif

endmodule
